cg_rv32_decode_stage: RTL and testbench
=======================================

# cg_rv32_decode_stage

RV32I instruction decode pipeline stage that sits between instruction fetch and the register-read/issue stage. It accepts one fetched instruction per cycle over a valid/ready handshake and extracts its fields, sign-extended immediate, rd-write enable and illegal flag. It drives them downstream from a registered output with a two-entry skid buffer, giving full throughput under backpressure. Field extraction and opcode constants come from the shared `CG_rvarch_instr_field_pkg`.

## Interface
- `PC_WIDTH`, 32, width of the program counter carried alongside the instruction.
- `i_clk` input 1: the single clock; all state updates on the rising edge.
- `i_rst_n` input 1: reset, asynchronous, active-low.
- `i_flush` input 1: synchronous pipeline flush.
- `i_valid` input 1: upstream instruction valid.
- `o_ready` output 1: stage can accept an instruction.
- `i_instr` input 32: raw instruction word.
- `i_pc` input PC_WIDTH: PC of `i_instr`.
- `o_valid` output 1: decoded instruction valid.
- `i_ready` input 1: downstream accepts.
- `o_pc` output PC_WIDTH: PC of the decoded instruction.
- `o_opcode`, `o_funct3`, `o_funct7` output 7/3/7: raw fields.
- `o_rd`, `o_rs1`, `o_rs2` output 5 each: register indices.
- `o_imm` output 32: format-selected, sign-extended immediate.
- `o_rd_wen` output 1: instruction writes a non-zero rd.
- `o_illegal` output 1: unsupported or malformed encoding.

## Operation
- Decode is combinational on `i_instr` and produces one payload: all decoded outputs plus the PC.
- The payload is captured into the output register, or into the skid register when the output is stalled.
- Immediate format by opcode:
  - I: LOAD, OP_IMM, JALR.
  - S: STORE.
  - B: BRANCH.
  - U: LUI, AUIPC. Value is `i_instr[31:12]` shifted left 12, low 12 bits zero.
  - J: JAL.
  - Any other opcode: 0.
- `o_rd_wen` = opcode in {LOAD, OP_IMM, AUIPC, OP, LUI, JAL, JALR} AND rd != 0 AND not illegal.
- `o_illegal` = `i_instr[1:0]` != 2'b11, OR opcode not in {LOAD, MISC_MEM, OP_IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, SYSTEM}.
  - Fields are still driven when illegal.
  - `o_imm` = 0 and `o_rd_wen` = 0 when illegal.
- The stage never drops or duplicates an instruction, and preserves order.

## Timing
- Reset (async assert, sync-release use): output valid = 0, skid valid = 0.
  - `o_valid` = 0, so `o_ready` = 1.
  - All data outputs are 0.
- Latency: an instruction accepted at edge N appears on `o_valid` after edge N when the output register is free.
- `o_ready` = NOT skid_valid, driven directly from a register with no combinational path from `i_ready`.
- State is the pair (out_valid, skid_valid). Transitions per edge:
  - EMPTY (0,0): accept -> ONE.
  - ONE (1,0):
    - accept with `i_ready`=1 -> ONE (new payload).
    - accept with `i_ready`=0 -> FULL (payload to skid).
    - no accept with `i_ready`=1 -> EMPTY.
  - FULL (1,1): `i_ready`=1 -> ONE (skid moves to output). No accept is possible since `o_ready`=0.
- Simultaneous drain and accept in ONE: the output register loads the new payload, giving zero bubbles.
- `i_flush` has priority over everything:
  - Next edge clears out_valid and skid_valid.
  - Any handshake in the flush cycle is discarded.
  - Data registers need not clear.
- Output data holds stable while `o_valid`=1 and `i_ready`=0.
- Reset asserted mid-operation: all valids clear immediately and in-flight instructions are lost.

## Structure
- Field extractors, opcode constants and immediate builders come from `CG_rvarch_instr_field_pkg`.
- Add to that package:
  - the `imm_fmt_e` enum {I, S, B, U, J, NONE};
  - a packed `decoded_instr_t` struct (pc excluded, parameterised separately);
  - an `is_legal_opcode` function.
- One sub-module: `cg_skid_buffer` (generic payload width, valid/ready, flush). It is reusable for other pipeline stages. The decode logic is the thin combinational front end.

## Test plan
- addi x1,x0,5 = 0x00500093, pc 0x100 -> next cycle `o_valid`=1, opcode 0x13, rd 1, rs1 0, imm 0x00000005, `o_rd_wen`=1, `o_illegal`=0.
- sw x2,-4(x1) = 0xFE20AE23 -> imm 0xFFFFFFFC, rs1 1, rs2 2, funct3 2, `o_rd_wen`=0.
- lui x5,0x12345 = 0x123452B7 -> imm 0x12345000, rd 5, `o_rd_wen`=1.
- jal x0,-8 = 0xFF9FF06F -> imm 0xFFFFFFF8, `o_rd_wen`=0.
- 0x00000000 -> `o_illegal`=1, imm 0, `o_rd_wen`=0.
- Backpressure: stream pcs 0x0, 0x4, 0x8 back-to-back with `i_ready`=0 for 2 cycles.
  - `o_ready` drops one cycle after the skid fills.
  - Outputs pcs 0x0, 0x4, 0x8 in order with no loss or duplication.
  - Full throughput resumes once `i_ready`=1.
- Flush in FULL state -> next cycle `o_valid`=0, `o_ready`=1. An instruction presented in the flush cycle never appears.

Source files
------------

// File: rtl/CG_rvarch_instr_field_pkg.sv
// Shared RV32I instruction-field package: opcode constants, field
// extractors, immediate builders and the decoded-instruction payload type.
package CG_rvarch_instr_field_pkg;

  // Major opcodes (instr[6:0]) of the RV32I base ISA.
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  // Immediate encoding formats.
  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  // Decoded instruction without the PC; the PC width is chosen per stage.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        rd_wen;
    logic        illegal;
  } decoded_instr_t;

  // Raw field extractors.
  function automatic logic [6:0] get_opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [4:0] get_rd(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [2:0] get_funct3(input logic [31:0] instr);
    return instr[14:12];
  endfunction

  function automatic logic [4:0] get_rs1(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] get_rs2(input logic [31:0] instr);
    return instr[24:20];
  endfunction

  function automatic logic [6:0] get_funct7(input logic [31:0] instr);
    return instr[31:25];
  endfunction

  // Immediate builders, one per format, all sign-extended from instr[31].
  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  // Which immediate format an opcode carries.
  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: return IMM_I;
      OPC_STORE:                      return IMM_S;
      OPC_BRANCH:                     return IMM_B;
      OPC_LUI, OPC_AUIPC:             return IMM_U;
      OPC_JAL:                        return IMM_J;
      default:                        return IMM_NONE;
    endcase
  endfunction

  // Opcodes supported by this RV32I implementation.
  function automatic logic is_legal_opcode(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

  // Opcodes whose instructions write a destination register.
  function automatic logic writes_rd(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP, OPC_LUI, OPC_JAL, OPC_JALR: return 1'b1;
      default:                                                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cg_rv32_decode_stage_if.sv
// Fetch-to-decode and decode-to-issue handshake bundle of the decode stage.
interface cg_rv32_decode_stage_if #(
  parameter int PC_WIDTH = 32
);
  logic                i_flush;
  logic                i_valid;
  logic                o_ready;
  logic [31:0]         i_instr;
  logic [PC_WIDTH-1:0] i_pc;
  logic                o_valid;
  logic                i_ready;
  logic [PC_WIDTH-1:0] o_pc;
  logic [6:0]          o_opcode;
  logic [2:0]          o_funct3;
  logic [6:0]          o_funct7;
  logic [4:0]          o_rd;
  logic [4:0]          o_rs1;
  logic [4:0]          o_rs2;
  logic [31:0]         o_imm;
  logic                o_rd_wen;
  logic                o_illegal;

  // Environment side: supplies instructions and downstream ready.
  modport master (
    output i_flush, i_valid, i_instr, i_pc, i_ready,
    input  o_ready, o_valid, o_pc, o_opcode, o_funct3, o_funct7,
           o_rd, o_rs1, o_rs2, o_imm, o_rd_wen, o_illegal
  );

  // Decode stage side.
  modport slave (
    input  i_flush, i_valid, i_instr, i_pc, i_ready,
    output o_ready, o_valid, o_pc, o_opcode, o_funct3, o_funct7,
           o_rd, o_rs1, o_rs2, o_imm, o_rd_wen, o_illegal
  );
endinterface

// File: rtl/cg_skid_buffer.sv
// Generic two-entry skid buffer: registered output plus one skid register,
// full throughput under backpressure, o_ready taken straight from a flop.
module cg_skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  // Encoding is {skid_valid, out_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

  state_e           state;
  logic             out_valid_q;
  logic             ready_q;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] skid_data_q;

  // Occupancy FSM with registered valid/ready and the two data registers.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the data registers are reset too, because the stage must
      // present all-zero data outputs after reset, not just clear valid.
      state       <= ST_EMPTY;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      out_data_q  <= '0;
      skid_data_q <= '0;
    end else if (i_flush) begin
      // Flush wins over any handshake in the same cycle; data may stay stale.
      state       <= ST_EMPTY;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (i_valid) begin
            out_data_q  <= i_data;
            out_valid_q <= 1'b1;
            state       <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (i_valid && i_ready) begin
            // Drain and refill in one edge: no bubble.
            out_data_q <= i_data;
          end else if (i_valid) begin
            skid_data_q <= i_data;
            ready_q     <= 1'b0;
            state       <= ST_FULL;
          end else if (i_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // o_ready is low here, so nothing new can be accepted.
          if (i_ready) begin
            out_data_q <= skid_data_q;
            ready_q    <= 1'b1;
            state      <= ST_ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          state       <= ST_EMPTY;
        end
      endcase
    end
  end

  assign o_valid = out_valid_q;
  assign o_ready = ready_q;
  assign o_data  = out_data_q;

endmodule

// File: rtl/cg_rv32_decode_stage.sv
// RV32I decode stage: combinational field/immediate decode feeding a
// skid-buffered registered output towards register-read/issue.
module cg_rv32_decode_stage
  import CG_rvarch_instr_field_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  cg_rv32_decode_stage_if.slave bus
);

  localparam int DEC_W     = $bits(decoded_instr_t);
  localparam int PAYLOAD_W = PC_WIDTH + DEC_W;

  decoded_instr_t       dec;
  decoded_instr_t       out_dec;
  imm_fmt_e             fmt;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] out_payload;

  // Thin decode front end: fields, format-selected immediate, wen, illegal.
  // NOTE: combinational logic uses blocking assignments and gives every
  // output a default first, so no path can leave a latch behind.
  always_comb begin
    dec         = '0;
    dec.opcode  = get_opcode(bus.i_instr);
    dec.funct3  = get_funct3(bus.i_instr);
    dec.funct7  = get_funct7(bus.i_instr);
    dec.rd      = get_rd(bus.i_instr);
    dec.rs1     = get_rs1(bus.i_instr);
    dec.rs2     = get_rs2(bus.i_instr);
    dec.illegal = (bus.i_instr[1:0] != 2'b11) || !is_legal_opcode(dec.opcode);
    fmt         = imm_fmt_of(dec.opcode);
    case (fmt)
      IMM_I:   dec.imm = imm_i(bus.i_instr);
      IMM_S:   dec.imm = imm_s(bus.i_instr);
      IMM_B:   dec.imm = imm_b(bus.i_instr);
      IMM_U:   dec.imm = imm_u(bus.i_instr);
      IMM_J:   dec.imm = imm_j(bus.i_instr);
      default: dec.imm = '0;
    endcase
    // Illegal encodings still expose raw fields but never an immediate or a write.
    if (dec.illegal) begin
      dec.imm = '0;
    end
    dec.rd_wen = writes_rd(dec.opcode) && (dec.rd != 5'd0) && !dec.illegal;
  end

  assign in_payload = {bus.i_pc, dec};

  cg_skid_buffer #(
    .WIDTH(PAYLOAD_W)
  ) u_skid (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_flush(bus.i_flush),
    .i_valid(bus.i_valid),
    .o_ready(bus.o_ready),
    .i_data (in_payload),
    .o_valid(bus.o_valid),
    .i_ready(bus.i_ready),
    .o_data (out_payload)
  );

  assign out_dec       = out_payload[DEC_W-1:0];
  assign bus.o_pc      = out_payload[PAYLOAD_W-1 -: PC_WIDTH];
  assign bus.o_opcode  = out_dec.opcode;
  assign bus.o_funct3  = out_dec.funct3;
  assign bus.o_funct7  = out_dec.funct7;
  assign bus.o_rd      = out_dec.rd;
  assign bus.o_rs1     = out_dec.rs1;
  assign bus.o_rs2     = out_dec.rs2;
  assign bus.o_imm     = out_dec.imm;
  assign bus.o_rd_wen  = out_dec.rd_wen;
  assign bus.o_illegal = out_dec.illegal;

endmodule

// File: tb/tb_cg_rv32_decode_stage.sv
// Self-checking bench for cg_rv32_decode_stage: directed test-plan steps,
// then randomized traffic against a FIFO-of-two reference model.
module tb_cg_rv32_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        rd_wen;
    logic        illegal;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic [31:0] pc_log[$];

  cg_rv32_decode_stage_if #(.PC_WIDTH(32)) ifc ();

  cg_rv32_decode_stage #(.PC_WIDTH(32)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (ifc.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the ISA rules with integer arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int   op;
    int   top;
    int   hi7;
    int   hi12;
    int   imm;
    bit   legal;
    bit   wr;
    op    = int'(w[6:0]);
    top   = $signed(w) >>> 31;
    hi7   = $signed(w) >>> 25;
    hi12  = $signed(w) >>> 20;
    legal = (w[1:0] == 2'b11) &&
            (op inside {'h03, 'h0F, 'h13, 'h17, 'h23, 'h33, 'h37, 'h63, 'h67, 'h6F, 'h73});
    wr    = op inside {'h03, 'h13, 'h17, 'h33, 'h37, 'h6F, 'h67};
    case (op)
      'h03, 'h13, 'h67: imm = hi12;
      'h23:             imm = hi7 * 32 + int'(w[11:7]);
      'h63:             imm = top * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      'h37, 'h17:       imm = int'(w & 32'hFFFF_F000);
      'h6F:             imm = top * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      default:          imm = 0;
    endcase
    e.pc      = pc;
    e.opcode  = w[6:0];
    e.funct3  = w[14:12];
    e.funct7  = w[31:25];
    e.rd      = w[11:7];
    e.rs1     = w[19:15];
    e.rs2     = w[24:20];
    e.imm     = legal ? imm : 0;
    e.rd_wen  = legal && wr && (w[11:7] != 0);
    e.illegal = !legal;
    return e;
  endfunction

  function automatic exp_t dut_out();
    exp_t e;
    e.pc      = ifc.o_pc;
    e.opcode  = ifc.o_opcode;
    e.funct3  = ifc.o_funct3;
    e.funct7  = ifc.o_funct7;
    e.rd      = ifc.o_rd;
    e.rs1     = ifc.o_rs1;
    e.rs2     = ifc.o_rs2;
    e.imm     = ifc.o_imm;
    e.rd_wen  = ifc.o_rd_wen;
    e.illegal = ifc.o_illegal;
    return e;
  endfunction

  // Model state (capacity-two FIFO) against the DUT, just after an edge.
  task automatic check_state(input string tag);
    check({tag, ".o_valid"}, 128'(ifc.o_valid), 128'(exp_q.size() > 0));
    check({tag, ".o_ready"}, 128'(ifc.o_ready), 128'(exp_q.size() < 2));
    if (exp_q.size() > 0) begin
      check({tag, ".payload"}, 128'(dut_out()), 128'(exp_q[0]));
    end
  endtask

  // Update the model with this cycle's handshake, clock once, then compare.
  task automatic tick(input string tag);
    bit   acc;
    bit   xfer;
    exp_t head;
    acc  = ifc.i_valid && (exp_q.size() < 2);
    xfer = ifc.i_ready && (exp_q.size() > 0);
    if (ifc.i_flush) begin
      exp_q.delete();
    end else begin
      if (xfer) begin
        head = exp_q.pop_front();
        pc_log.push_back(head.pc);
      end
      if (acc) exp_q.push_back(ref_decode(ifc.i_instr, ifc.i_pc));
    end
    @(posedge i_clk);
    #1;
    check_state(tag);
  endtask

  task automatic drive(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                       input bit rdy, input bit fl);
    ifc.i_valid = v;
    ifc.i_instr = instr;
    ifc.i_pc    = pc;
    ifc.i_ready = rdy;
    ifc.i_flush = fl;
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] pc;
    logic [6:0]  opc_tab [0:10];
    opc_tab = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

    // Reset state.
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    check("reset.o_valid", 128'(ifc.o_valid), 128'(1'b0));
    check("reset.o_ready", 128'(ifc.o_ready), 128'(1'b1));
    check("reset.data", 128'(dut_out()), 128'(0));
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // addi x1,x0,5
    drive(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0);
    tick("addi");
    check("addi.o_valid", 128'(ifc.o_valid), 128'(1'b1));
    check("addi.opcode", 128'(ifc.o_opcode), 128'(7'h13));
    check("addi.rd", 128'(ifc.o_rd), 128'(5'd1));
    check("addi.rs1", 128'(ifc.o_rs1), 128'(5'd0));
    check("addi.imm", 128'(ifc.o_imm), 128'(32'h0000_0005));
    check("addi.wen", 128'(ifc.o_rd_wen), 128'(1'b1));
    check("addi.illegal", 128'(ifc.o_illegal), 128'(1'b0));
    check("addi.pc", 128'(ifc.o_pc), 128'(32'h100));

    // sw x2,-4(x1)
    drive(1'b1, 32'hFE20_AE23, 32'h104, 1'b1, 1'b0);
    tick("sw");
    check("sw.imm", 128'(ifc.o_imm), 128'(32'hFFFF_FFFC));
    check("sw.rs1", 128'(ifc.o_rs1), 128'(5'd1));
    check("sw.rs2", 128'(ifc.o_rs2), 128'(5'd2));
    check("sw.funct3", 128'(ifc.o_funct3), 128'(3'd2));
    check("sw.wen", 128'(ifc.o_rd_wen), 128'(1'b0));

    // lui x5,0x12345
    drive(1'b1, 32'h1234_52B7, 32'h108, 1'b1, 1'b0);
    tick("lui");
    check("lui.imm", 128'(ifc.o_imm), 128'(32'h1234_5000));
    check("lui.rd", 128'(ifc.o_rd), 128'(5'd5));
    check("lui.wen", 128'(ifc.o_rd_wen), 128'(1'b1));

    // jal x0,-8
    drive(1'b1, 32'hFF9F_F06F, 32'h10C, 1'b1, 1'b0);
    tick("jal");
    check("jal.imm", 128'(ifc.o_imm), 128'(32'hFFFF_FFF8));
    check("jal.wen", 128'(ifc.o_rd_wen), 128'(1'b0));

    // All-zero word is illegal.
    drive(1'b1, 32'h0000_0000, 32'h110, 1'b1, 1'b0);
    tick("zero");
    check("zero.illegal", 128'(ifc.o_illegal), 128'(1'b1));
    check("zero.imm", 128'(ifc.o_imm), 128'(32'h0));
    check("zero.wen", 128'(ifc.o_rd_wen), 128'(1'b0));
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick("drain");

    // Backpressure: stream 0x0, 0x4, 0x8 with i_ready low for the first cycles.
    pc_log.delete();
    drive(1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0);
    tick("bp.a0");
    drive(1'b1, 32'h0050_0113, 32'h4, 1'b0, 1'b0);
    tick("bp.a4");
    check("bp.ready_low", 128'(ifc.o_ready), 128'(1'b0));
    drive(1'b1, 32'h0050_0193, 32'h8, 1'b0, 1'b0);
    tick("bp.stall");
    check("bp.hold_pc", 128'(ifc.o_pc), 128'(32'h0));
    drive(1'b1, 32'h0050_0193, 32'h8, 1'b1, 1'b0);
    tick("bp.unskid");
    check("bp.ready_back", 128'(ifc.o_ready), 128'(1'b1));
    tick("bp.a8");
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick("bp.last");
    tick("bp.empty");
    check("bp.count", 128'(pc_log.size()), 128'(3));
    if (pc_log.size() == 3) begin
      check("bp.order0", 128'(pc_log[0]), 128'(32'h0));
      check("bp.order1", 128'(pc_log[1]), 128'(32'h4));
      check("bp.order2", 128'(pc_log[2]), 128'(32'h8));
    end

    // Flush in FULL: state clears, the flush-cycle instruction never appears.
    drive(1'b1, 32'h0050_0093, 32'h300, 1'b0, 1'b0);
    tick("fl.a");
    drive(1'b1, 32'h0050_0093, 32'h304, 1'b0, 1'b0);
    tick("fl.b");
    drive(1'b1, 32'h0050_0093, 32'h308, 1'b1, 1'b1);
    tick("fl.flush");
    check("fl.o_valid", 128'(ifc.o_valid), 128'(1'b0));
    check("fl.o_ready", 128'(ifc.o_ready), 128'(1'b1));
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (2) tick("fl.after");

    // Randomized traffic with occasional flushes.
    pc = 32'h1000;
    for (int i = 0; i < 800; i++) begin
      rnd = $urandom;
      if ($urandom_range(0, 3) != 0) rnd[6:0] = opc_tab[$urandom_range(0, 10)];
      drive($urandom_range(0, 3) != 0, rnd, pc, $urandom_range(0, 2) != 0,
            $urandom_range(0, 40) == 0);
      tick("rand");
      pc = pc + 32'd4;
      @(negedge i_clk);
    end

    // Reset mid-operation: valids clear immediately.
    drive(1'b1, 32'h0050_0093, 32'h2000, 1'b0, 1'b0);
    tick("rst.fill");
    tick("rst.fill2");
    #2;
    i_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst.o_valid", 128'(ifc.o_valid), 128'(1'b0));
    check("rst.o_ready", 128'(ifc.o_ready), 128'(1'b1));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick("rst.after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
